median_filter_core: RTL and testbench

- Streaming 5x5 median stage directly downstream of the line/kernel buffer.
- Consumes one 5x5 window per clock for each colour channel (R, G, B), together with the window-centre sync flags.
- Emits the per-channel median pixel with sync flags aligned at a fixed 3-cycle latency.
- Filtering can be bypassed (centre pixel passed through); the enable is applied only at frame boundaries.

---
 rtl/median_pkg.sv | 23 ++
 rtl/median25_rank.sv | 94 +++++++++
 rtl/median_filter_core.sv | 89 ++++++++
 tb/tb_median_filter_core.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/median_pkg.sv
// Shared constants and helpers for the 5x5 rank-select median filter.
// Holds window size, median rank, centre index, pipeline depth and rank width.
package median_pkg;

   localparam int KN         = 25;
   localparam int MED_RANK   = 12;
   localparam int CENTER_IDX = 12;
   localparam int PIPE_LAT   = 3;
   localparam int RANK_W     = 5;

   // Count of set bits in a 25-bit precedence row; max 24 fits RANK_W.
   function automatic logic [RANK_W-1:0] popcnt(
      input logic [KN-1:0] b
   );
      logic [RANK_W-1:0] c;
      c = '0;
      for (int k = 0; k < KN; k++) begin
         c = c + {{(RANK_W-1){1'b0}}, b[k]};
      end
      return c;
   endfunction

endpackage

// File: rtl/median25_rank.sv
// Three-stage rank-select median of one 25-element channel window.
// Ports: clk, rst (async high), win_i (25 packed pixels), en_i (1=median,
// 0=centre bypass, taken with the window), vld_i (stage-3 qualifier,
// output forced 0 when low), pix_o (registered result).
module median25_rank
   import median_pkg::*;
#(
   parameter int PIX_W = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [KN*PIX_W-1:0]   win_i,
   input  logic                  en_i,
   input  logic                  vld_i,
   output logic [PIX_W-1:0]      pix_o
);

   logic [KN-1:0][PIX_W-1:0]  v0;
   logic [KN-1:0][KN-1:0]     bef_d;
   logic [KN-1:0][KN-1:0]     bef_q;
   logic [KN-1:0][PIX_W-1:0]  v1_q;
   logic [KN-1:0][PIX_W-1:0]  v2_q;
   logic [PIX_W-1:0]          c1_q;
   logic [PIX_W-1:0]          c2_q;
   logic                      en1_q;
   logic                      en2_q;
   logic [KN-1:0][RANK_W-1:0] rank_d;
   logic [KN-1:0][RANK_W-1:0] rank_q;
   logic [PIX_W-1:0]          med;
   logic [PIX_W-1:0]          pix_d;

   assign v0 = win_i;

   // bef_d[i][j]: element j precedes element i. Ties broken by index so
   // the order is strict and exactly one element lands on the median rank.
   always_comb begin
      bef_d = '0;
      for (int i = 0; i < KN; i++) begin
         for (int j = 0; j < KN; j++) begin
            bef_d[i][j] = (v0[j] < v0[i]) ||
                          ((v0[j] == v0[i]) && (j < i));
         end
      end
   end

   always_comb begin
      rank_d = '0;
      for (int i = 0; i < KN; i++) begin
         rank_d[i] = popcnt(bef_q[i]);
      end
   end

   // Rank is unique, so OR-ing the masked values yields the single winner.
   always_comb begin
      med = '0;
      for (int i = 0; i < KN; i++) begin
         if (rank_q[i] == RANK_W'(MED_RANK)) begin
            med = med | v2_q[i];
         end
      end
   end

   always_comb begin
      pix_d = '0;
      if (vld_i) begin
         pix_d = en2_q ? med : c2_q;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bef_q  <= '0;
         v1_q   <= '0;
         c1_q   <= '0;
         en1_q  <= 1'b0;
         rank_q <= '0;
         v2_q   <= '0;
         c2_q   <= '0;
         en2_q  <= 1'b0;
         pix_o  <= '0;
      end else begin
         bef_q  <= bef_d;
         v1_q   <= v0;
         c1_q   <= v0[CENTER_IDX];
         en1_q  <= en_i;
         rank_q <= rank_d;
         v2_q   <= v1_q;
         c2_q   <= c1_q;
         en2_q  <= en1_q;
         pix_o  <= pix_d;
      end
   end

endmodule

// File: rtl/median_filter_core.sv
// Streaming 5x5 RGB median stage with frame-aligned bypass and 3-cycle latency.
// Ports: clk, rst (async high), rx_dv/hs/vs + kernel_red/green/blue in,
// filt_en (sampled on rx_vs rise), tx_red/green/blue + tx_dv/hs/vs out.
module median_filter_core #(
   parameter int PIX_W = 8,
   parameter int KN    = 25
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               rx_dv,
   input  logic               rx_hs,
   input  logic               rx_vs,
   input  logic [KN*PIX_W-1:0] kernel_red,
   input  logic [KN*PIX_W-1:0] kernel_green,
   input  logic [KN*PIX_W-1:0] kernel_blue,
   input  logic               filt_en,
   output logic [PIX_W-1:0]   tx_red,
   output logic [PIX_W-1:0]   tx_green,
   output logic [PIX_W-1:0]   tx_blue,
   output logic               tx_dv,
   output logic               tx_hs,
   output logic               tx_vs
);

   localparam int LAT = median_pkg::PIPE_LAT;

   logic           vs_prev_q;
   logic           en_q;
   logic           en_d;
   logic [LAT-1:0] dv_sr_q;
   logic [LAT-1:0] hs_sr_q;
   logic [LAT-1:0] vs_sr_q;
   logic           vld3;

   // The pixel on the rising-vs cycle already sees the new mode, so the
   // pipeline takes the next-state value rather than en_q itself.
   assign en_d = (rx_vs && !vs_prev_q) ? filt_en : en_q;

   // dv of the sample currently held in stage 2, qualifying stage 3.
   assign vld3 = dv_sr_q[LAT-2];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vs_prev_q <= 1'b0;
         en_q      <= 1'b0;
         dv_sr_q   <= '0;
         hs_sr_q   <= '0;
         vs_sr_q   <= '0;
      end else begin
         vs_prev_q <= rx_vs;
         en_q      <= en_d;
         dv_sr_q   <= {dv_sr_q[LAT-2:0], rx_dv};
         hs_sr_q   <= {hs_sr_q[LAT-2:0], rx_hs};
         vs_sr_q   <= {vs_sr_q[LAT-2:0], rx_vs};
      end
   end

   assign tx_dv = dv_sr_q[LAT-1];
   assign tx_hs = hs_sr_q[LAT-1];
   assign tx_vs = vs_sr_q[LAT-1];

   median25_rank #(.PIX_W(PIX_W)) u_red (
      .clk   (clk),
      .rst   (rst),
      .win_i (kernel_red),
      .en_i  (en_d),
      .vld_i (vld3),
      .pix_o (tx_red)
   );

   median25_rank #(.PIX_W(PIX_W)) u_green (
      .clk   (clk),
      .rst   (rst),
      .win_i (kernel_green),
      .en_i  (en_d),
      .vld_i (vld3),
      .pix_o (tx_green)
   );

   median25_rank #(.PIX_W(PIX_W)) u_blue (
      .clk   (clk),
      .rst   (rst),
      .win_i (kernel_blue),
      .en_i  (en_d),
      .vld_i (vld3),
      .pix_o (tx_blue)
   );

endmodule

// File: tb/tb_median_filter_core.sv
// Directed-table and random-window bench for median_filter_core.
// Expected values are hand-derived or come from a sort-based reference.
module tb_median_filter_core;

   localparam int PW = 8;
   localparam int NK = 25;
   localparam int KW = PW * NK;

   logic          clk = 1'b0;
   logic          rst;
   logic          rx_dv, rx_hs, rx_vs, filt_en;
   logic [KW-1:0] kernel_red, kernel_green, kernel_blue;
   logic [PW-1:0] tx_red, tx_green, tx_blue;
   logic          tx_dv, tx_hs, tx_vs;

   always #5 clk = ~clk;

   median_filter_core #(.PIX_W(PW), .KN(NK)) dut (
      .clk          (clk),
      .rst          (rst),
      .rx_dv        (rx_dv),
      .rx_hs        (rx_hs),
      .rx_vs        (rx_vs),
      .kernel_red   (kernel_red),
      .kernel_green (kernel_green),
      .kernel_blue  (kernel_blue),
      .filt_en      (filt_en),
      .tx_red       (tx_red),
      .tx_green     (tx_green),
      .tx_blue      (tx_blue),
      .tx_dv        (tx_dv),
      .tx_hs        (tx_hs),
      .tx_vs        (tx_vs)
   );

   typedef struct {
      logic          dv, hs, vs, fe;
      logic [KW-1:0] kr, kg, kb;
      logic [PW-1:0] er, eg, eb;
   } vec_t;

   typedef struct {
      logic          dv, hs, vs;
      logic [PW-1:0] r, g, b;
   } exp_t;

   exp_t exp_q[$];
   int   n_cmp = 0;
   int   n_bad = 0;
   int   cyc   = 0;

   function automatic logic [KW-1:0] k_const(input logic [PW-1:0] v);
      logic [KW-1:0] k;
      for (int i = 0; i < NK; i++) k[i*PW +: PW] = v;
      return k;
   endfunction

   // permutation of 0..24, centre = 16
   function automatic logic [KW-1:0] k_perm();
      logic [KW-1:0] k;
      for (int i = 0; i < NK; i++) k[i*PW +: PW] = PW'((i*3 + 5) % 25);
      return k;
   endfunction

   // permutation of 100..124, centre = 109
   function automatic logic [KW-1:0] k_grn();
      logic [KW-1:0] k;
      for (int i = 0; i < NK; i++) k[i*PW +: PW] = PW'(100 + (i*7) % 25);
      return k;
   endfunction

   // 13 x 0xFF, 12 x 0x00, centre = 0x00
   function automatic logic [KW-1:0] k_blu();
      logic [KW-1:0] k;
      for (int i = 0; i < NK; i++)
         k[i*PW +: PW] = (i <= 11 || i == 13) ? 8'hFF : 8'h00;
      return k;
   endfunction

   // flat 0x40 with three 0xFF impulses, one at the centre
   function automatic logic [KW-1:0] k_imp();
      logic [KW-1:0] k;
      for (int i = 0; i < NK; i++)
         k[i*PW +: PW] = (i == 3 || i == 7 || i == 12) ? 8'hFF : 8'h40;
      return k;
   endfunction

   function automatic logic [PW-1:0] ref_med(input logic [KW-1:0] k);
      logic [PW-1:0] a [NK];
      logic [PW-1:0] t;
      for (int i = 0; i < NK; i++) a[i] = k[i*PW +: PW];
      for (int i = 1; i < NK; i++) begin
         for (int j = i; j > 0; j--) begin
            if (a[j] < a[j-1]) begin
               t = a[j]; a[j] = a[j-1]; a[j-1] = t;
            end
         end
      end
      return a[12];
   endfunction

   function automatic vec_t mkv(
      input logic dv, hs, vs, fe,
      input logic [KW-1:0] kr, kg, kb,
      input logic [PW-1:0] er, eg, eb
   );
      vec_t v;
      v.dv = dv; v.hs = hs; v.vs = vs; v.fe = fe;
      v.kr = kr; v.kg = kg; v.kb = kb;
      v.er = er; v.eg = eg; v.eb = eb;
      return v;
   endfunction

   task automatic flush_exp();
      exp_t z;
      z.dv = 0; z.hs = 0; z.vs = 0; z.r = 0; z.g = 0; z.b = 0;
      exp_q.delete();
      repeat (3) exp_q.push_back(z);
   endtask

   // Check the output due now, drive one new sample, advance one clock.
   task automatic step(input vec_t v);
      exp_t e;
      if (exp_q.size() == 3) begin
         e = exp_q.pop_front();
         n_cmp++;
         if ({tx_dv, tx_hs, tx_vs} !== {e.dv, e.hs, e.vs}) begin
            n_bad++;
            $display("FAIL sync cyc%0d got dv/hs/vs=%b%b%b want %b%b%b",
                     cyc, tx_dv, tx_hs, tx_vs, e.dv, e.hs, e.vs);
         end
         n_cmp++;
         if ({tx_red, tx_green, tx_blue} !== {e.r, e.g, e.b}) begin
            n_bad++;
            $display("FAIL rgb cyc%0d got %h_%h_%h want %h_%h_%h",
                     cyc, tx_red, tx_green, tx_blue, e.r, e.g, e.b);
         end
      end
      rx_dv = v.dv; rx_hs = v.hs; rx_vs = v.vs; filt_en = v.fe;
      kernel_red = v.kr; kernel_green = v.kg; kernel_blue = v.kb;
      e.dv = v.dv; e.hs = v.hs; e.vs = v.vs;
      e.r = v.er; e.g = v.eg; e.b = v.eb;
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      cyc++;
   endtask

   vec_t tbl [13];
   vec_t post [4];
   vec_t idle;
   vec_t rv;

   initial begin
      logic [KW-1:0] c5a, c00, cff, prm, grn, blu, imp;
      c5a = k_const(8'h5A);
      c00 = k_const(8'h00);
      cff = k_const(8'hFF);
      prm = k_perm();
      grn = k_grn();
      blu = k_blu();
      imp = k_imp();

      //               dv hs vs fe  kr   kg   kb   er     eg     eb
      tbl[0]  = mkv(0, 0, 1, 1, c5a, c5a, c5a, 8'h00, 8'h00, 8'h00);
      tbl[1]  = mkv(1, 0, 0, 1, c5a, grn, blu, 8'h5A, 8'h70, 8'hFF);
      tbl[2]  = mkv(1, 1, 0, 1, prm, grn, blu, 8'h0C, 8'h70, 8'hFF);
      tbl[3]  = mkv(1, 1, 0, 1, imp, imp, imp, 8'h40, 8'h40, 8'h40);
      tbl[4]  = mkv(0, 0, 0, 1, imp, imp, imp, 8'h00, 8'h00, 8'h00);
      tbl[5]  = mkv(1, 0, 0, 0, imp, imp, imp, 8'h40, 8'h40, 8'h40);
      tbl[6]  = mkv(1, 0, 0, 0, prm, grn, blu, 8'h0C, 8'h70, 8'hFF);
      tbl[7]  = mkv(0, 1, 1, 0, prm, grn, blu, 8'h00, 8'h00, 8'h00);
      tbl[8]  = mkv(1, 0, 1, 1, imp, imp, imp, 8'hFF, 8'hFF, 8'hFF);
      tbl[9]  = mkv(1, 0, 0, 1, prm, grn, blu, 8'h10, 8'h6D, 8'h00);
      tbl[10] = mkv(1, 0, 1, 1, imp, imp, imp, 8'h40, 8'h40, 8'h40);
      tbl[11] = mkv(1, 1, 0, 0, prm, grn, blu, 8'h0C, 8'h70, 8'hFF);
      tbl[12] = mkv(1, 0, 0, 0, c5a, c00, cff, 8'h5A, 8'h00, 8'hFF);

      // after a mid-stream reset: bypass until the next vs rise
      post[0] = mkv(1, 0, 0, 1, imp, imp, imp, 8'hFF, 8'hFF, 8'hFF);
      post[1] = mkv(1, 0, 0, 1, prm, grn, blu, 8'h10, 8'h6D, 8'h00);
      post[2] = mkv(0, 0, 1, 1, imp, imp, imp, 8'h00, 8'h00, 8'h00);
      post[3] = mkv(1, 1, 0, 0, imp, imp, imp, 8'h40, 8'h40, 8'h40);

      idle = mkv(0, 0, 0, 0, c5a, c5a, c5a, 8'h00, 8'h00, 8'h00);

      rst = 1'b1;
      rx_dv = 0; rx_hs = 0; rx_vs = 0; filt_en = 0;
      kernel_red = '0; kernel_green = '0; kernel_blue = '0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      flush_exp();

      repeat (2) step(idle);
      for (int n = 0; n < 13; n++) step(tbl[n]);
      step(tbl[3]);
      step(tbl[3]);

      // one-cycle reset while the pipeline holds non-zero results
      rst = 1'b1;
      #1;
      n_cmp++;
      if ({tx_dv, tx_hs, tx_vs, tx_red, tx_green, tx_blue} !== '0) begin
         n_bad++;
         $display("FAIL rst_async got %b%b%b %h_%h_%h want all zero",
                  tx_dv, tx_hs, tx_vs, tx_red, tx_green, tx_blue);
      end
      rx_dv = 0; rx_hs = 0; rx_vs = 0; filt_en = 0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      flush_exp();

      for (int n = 0; n < 4; n++) step(post[n]);

      // back-to-back random windows; filt_en wiggles mid-frame with no effect
      for (int n = 0; n < 1000; n++) begin
         logic [KW-1:0] r, g, b;
         for (int i = 0; i < NK; i++) begin
            if (n % 2 == 1) begin
               r[i*PW +: PW] = PW'($urandom_range(0, 7));
               g[i*PW +: PW] = PW'($urandom_range(0, 7));
               b[i*PW +: PW] = PW'($urandom_range(0, 7));
            end else begin
               r[i*PW +: PW] = PW'($urandom_range(0, 255));
               g[i*PW +: PW] = PW'($urandom_range(0, 255));
               b[i*PW +: PW] = PW'($urandom_range(0, 255));
            end
         end
         rv.dv = ($urandom_range(0, 7) != 0);
         rv.hs = 1'($urandom_range(0, 1));
         rv.vs = 1'b0;
         rv.fe = 1'($urandom_range(0, 1));
         rv.kr = r; rv.kg = g; rv.kb = b;
         rv.er = rv.dv ? ref_med(r) : 8'h00;
         rv.eg = rv.dv ? ref_med(g) : 8'h00;
         rv.eb = rv.dv ? ref_med(b) : 8'h00;
         step(rv);
      end

      repeat (4) step(idle);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
